branch_cond_unit: RTL and testbench
===================================

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits, legal range 8..64.
REQ-002 Parameter COND_LSB, default 19: bit position of the 4-bit condition field IR[COND_LSB+3:COND_LSB].
REQ-003 Parameter CNT_W, default 16: width of the taken-branch counter.
REQ-004 clock  input  1  single clock for the block; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 busContents  input  WIDTH  operand value driven on the bus.
REQ-007 IR  input  32  current instruction; supplies the condition field.
REQ-008 CONin  input  1  one-cycle strobe that captures the bus and advances evaluation.
REQ-009 cmp_mode  input  1  0 = compare bus against zero; 1 = compare two bus operands, A then B.
REQ-010 q  output  1  registered branch-condition result; holds until the next evaluation completes.
REQ-011 q_valid  output  1  one-cycle pulse when q has just been updated.
REQ-012 busy  output  1  high while operand A is held and the unit waits for operand B.
REQ-013 taken_count  output  CNT_W  saturating count of evaluations with result 1.

Function
REQ-014 The condition code c is IR[COND_LSB+3:COND_LSB], sampled on the CONin cycle that completes an evaluation.
REQ-015 Operands are X and Y: zero mode X = busContents, Y = 0; two-operand mode X = latched A, Y = busContents.
REQ-016 c[2:0] decode: 000 EQ, 001 NE, 010 GT signed, 011 LT signed, 100 GE signed, 101 LE signed, 110 GTU unsigned, 111 LTU unsigned.
REQ-017 Signed compares treat X and Y as two's complement of WIDTH bits; unsigned compares treat them as natural binary.
REQ-018 When c[3] = 1, the result is forced to 1 (unconditional) regardless of c[2:0] and the operands.
REQ-019 FSM states: IDLE, WAIT_B.
REQ-020 IDLE, CONin = 1, cmp_mode = 0: evaluate in zero mode; q updates and q_valid = 1 on the next cycle; state stays IDLE.
REQ-021 IDLE, CONin = 1, cmp_mode = 1: latch busContents into A; go to WAIT_B; busy = 1 from the next cycle; q and q_valid unchanged.
REQ-022 WAIT_B, CONin = 1: evaluate A against busContents; q updates and q_valid = 1 on the next cycle; return to IDLE; busy = 0 from the next cycle.
REQ-023 WAIT_B, CONin = 0: hold state and A indefinitely; cmp_mode is ignored.
REQ-024 cmp_mode is sampled only on an IDLE-state CONin.
REQ-025 Latency from the completing CONin to q / q_valid is exactly 1 clock.
REQ-026 Back-to-back zero-mode CONin strobes on consecutive cycles each produce a result; q_valid stays high for consecutive cycles.
REQ-027 taken_count increments by 1 on each cycle that q_valid = 1 and q = 1.
REQ-028 taken_count saturates at 2^CNT_W-1 and does not wrap.
REQ-029 q is unchanged while q_valid = 0.

Reset
REQ-030 While reset = 1 at a rising edge: q = 0, q_valid = 0, busy = 0, taken_count = 0, A = 0, state = IDLE.
REQ-031 Reset overrides a coincident CONin; no evaluation or latch occurs on that edge.
REQ-032 Reset asserted in WAIT_B discards A; the next CONin is treated as an IDLE strobe.

Verification
REQ-033 Zero mode, WIDTH = 32, IR c = 0011, bus = 0xFFFFFFFF -> q = 1 (signed LT), q_valid pulse 1 cycle after CONin; c = 0111 with same bus -> q = 0.
REQ-034 Two-operand mode: CONin with bus = 5, then 3 idle cycles, then CONin with bus = 7, c = 0010 -> busy high for 4 cycles, q = 0; repeat with c = 0011 -> q = 1.
REQ-035 Unsigned compare: A = 0x80000000, B = 1, c = 0110 -> q = 1; c = 0010 -> q = 0.
REQ-036 Unconditional: c = 1000, bus = 0 or any value -> q = 1 every time; taken_count increments once per evaluation.
REQ-037 Saturation: CNT_W = 4, 20 consecutive taken evaluations -> taken_count stops at 15.
REQ-038 Reset in WAIT_B with coincident CONin -> busy = 0, q = 0, no q_valid; the following CONin with cmp_mode = 1 latches a new A.

Source files
------------

// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// branch_cond_unit
//
// Evaluates a branch condition for a bus-based datapath. A 4-bit condition
// field taken from the instruction register selects one of eight compares
// (EQ, NE, signed GT/LT/GE/LE, unsigned GTU/LTU) or an unconditional "taken".
// The compare runs either against zero, using a single bus operand, or between
// two bus operands. In the two-operand case, operand A is latched on one
// CONin strobe and operand B is taken on a later strobe.
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   busContents  in   [WIDTH-1:0] operand value on the bus
//   IR           in   [31:0] current instruction; IR[COND_LSB+3:COND_LSB] = cond
//   CONin        in   strobe: capture the bus and advance evaluation
//   cmp_mode     in   0 = compare against zero, 1 = two operands (A then B)
//   q            out  registered condition result, held between evaluations
//   q_valid      out  one-cycle pulse when q has just been updated
//   busy         out  high while A is held and the unit waits for B
//   taken_count  out  [CNT_W-1:0] saturating count of results equal to 1
// ---------------------------------------------------------------------------
module branch_cond_unit #(
  parameter int WIDTH    = 32,
  parameter int COND_LSB = 19,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] busContents,
  input  logic [31:0]      IR,
  input  logic             CONin,
  input  logic             cmp_mode,
  output logic             q,
  output logic             q_valid,
  output logic             busy,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    WAIT_B = 1'b1
  } state_e;

  // Low three bits of the condition field select the compare.
  typedef enum logic [2:0] {
    C_EQ  = 3'b000,
    C_NE  = 3'b001,
    C_GT  = 3'b010,
    C_LT  = 3'b011,
    C_GE  = 3'b100,
    C_LE  = 3'b101,
    C_GTU = 3'b110,
    C_LTU = 3'b111
  } cond_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  logic [3:0]       cond;
  logic [WIDTH-1:0] op_x, op_y;
  logic             eval_fire;
  logic             latch_a;
  logic             result;

  // Only the condition field of IR is used; the rest of the instruction is
  // deliberately ignored.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR;

  // Compares X against Y for one condition code. Bit 3 of the code forces the
  // result to 1, whatever the operands are.
  function automatic logic cond_eval(input logic [3:0]       c,
                                     input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
    logic r;
    r = 1'b0;
    if (c[3]) begin
      r = 1'b1;
    end else begin
      unique case (cond_e'(c[2:0]))
        C_EQ:  r = (x == y);
        C_NE:  r = (x != y);
        C_GT:  r = ($signed(x) >  $signed(y));
        C_LT:  r = ($signed(x) <  $signed(y));
        C_GE:  r = ($signed(x) >= $signed(y));
        C_LE:  r = ($signed(x) <= $signed(y));
        C_GTU: r = (x > y);
        C_LTU: r = (x < y);
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    state_d       = state_q;
    a_d           = a_q;
    q_d           = q_q;
    q_valid_d     = 1'b0;
    taken_count_d = taken_count_q;

    cond = IR[COND_LSB +: 4];

    // In WAIT_B the held A is X and the bus is Y. Otherwise the bus is
    // compared against zero.
    if (state_q == WAIT_B) begin
      op_x = a_q;
      op_y = busContents;
    end else begin
      op_x = busContents;
      op_y = '0;
    end

    // cmp_mode only matters on an IDLE strobe. In WAIT_B, any strobe
    // completes the evaluation.
    eval_fire = CONin && ((state_q == WAIT_B) || !cmp_mode);
    latch_a   = CONin && (state_q == IDLE) && cmp_mode;
    result    = cond_eval(cond, op_x, op_y);

    if (latch_a) begin
      a_d     = busContents;
      state_d = WAIT_B;
    end

    if (eval_fire) begin
      q_d       = result;
      q_valid_d = 1'b1;
      state_d   = IDLE;
      // The count moves on the same edge that raises q_valid with q = 1.
      if (result && (taken_count_q != CNT_MAX)) begin
        taken_count_d = taken_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge inputs no matter how the statements are ordered.
    if (reset) begin
      // NOTE: A is a single register, not a memory, so it is reset. A
      // WAIT_B operand is then discarded cleanly and never leaks into a
      // later compare.
      state_q       <= IDLE;
      a_q           <= '0;
      q_q           <= 1'b0;
      q_valid_q     <= 1'b0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      q_q           <= q_d;
      q_valid_q     <= q_valid_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign q           = q_q;
  assign q_valid     = q_valid_q;
  assign busy        = (state_q == WAIT_B);
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_unit
//
// Directed testbench for branch_cond_unit. It uses two instances: one with
// default parameters, and one with CNT_W = 4 to test counter saturation.
// Both share the same inputs. Inputs change 1 ns after each rising edge, and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_branch_cond_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] busContents;
  logic [31:0] IR;
  logic        CONin;
  logic        cmp_mode;

  logic        q, q_valid, busy;
  logic [15:0] taken_count;
  logic        q2, q2_valid, busy2;
  logic [3:0]  taken_count2;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clock = ~clock;

  branch_cond_unit #(.WIDTH(32), .COND_LSB(19), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .busContents(busContents), .IR(IR),
    .CONin(CONin), .cmp_mode(cmp_mode), .q(q), .q_valid(q_valid),
    .busy(busy), .taken_count(taken_count)
  );

  branch_cond_unit #(.WIDTH(32), .COND_LSB(19), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .busContents(busContents), .IR(IR),
    .CONin(CONin), .cmp_mode(cmp_mode), .q(q2), .q_valid(q2_valid),
    .busy(busy2), .taken_count(taken_count2)
  );

  // Builds an instruction word with condition c in bits 22:19. The other
  // bits carry noise, so the test also shows that the field is taken from
  // the right position.
  function automatic logic [31:0] ir_of(input logic [3:0] c);
    logic [31:0] mask;
    mask = 32'hF << 19;
    return (32'hA5A5_A5A5 & ~mask) | ({28'd0, c} << 19);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One CONin strobe lasting a single clock. Leaving CONin low afterwards
  // lets consecutive calls form a continuous strobe.
  task automatic strobe(input logic [3:0] c, input logic mode, input logic [31:0] bus);
    CONin = 1'b1; cmp_mode = mode; IR = ir_of(c); busContents = bus;
    tick();
    CONin = 1'b0;
  endtask

  task automatic test_reset();
    // Reset with a coincident, otherwise-taken CONin.
    reset = 1'b1; CONin = 1'b1; cmp_mode = 1'b0; IR = ir_of(4'b1000); busContents = 32'h1;
    tick(); tick();
    reset = 1'b0; CONin = 1'b0;
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL rst_q: got %0b want 0", q); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_q_valid: got %0b want 0", q_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (taken_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", taken_count); end
    checks++; if (taken_count2 !== 4'd0) begin errors++; $display("FAIL rst_count2: got %0d want 0", taken_count2); end
    exp_cnt = 0;
  endtask

  task automatic test_zero_mode();
    // Signed LT: -1 < 0 is true.
    strobe(4'b0011, 1'b0, 32'hFFFF_FFFF);
    exp_cnt++;
    checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL zm_lt_valid: got %0b want 1", q_valid); end
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL zm_lt_q: got %0b want 1", q); end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL zm_lt_count: got %0d want %0d", taken_count, exp_cnt); end
    tick();
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL zm_valid_pulse: got %0b want 0", q_valid); end
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL zm_q_hold: got %0b want 1", q); end
    // Unsigned LTU: 0xFFFFFFFF < 0 is false.
    strobe(4'b0111, 1'b0, 32'hFFFF_FFFF);
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL zm_ltu_q: got %0b want 0", q); end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL zm_ltu_count: got %0d want %0d", taken_count, exp_cnt); end
    // Remaining decodes, all against zero.
    strobe(4'b0000, 1'b0, 32'd0);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL zm_eq0_q: got %0b want 1", q); end
    strobe(4'b0000, 1'b0, 32'd3);
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL zm_eq3_q: got %0b want 0", q); end
    strobe(4'b0001, 1'b0, 32'd3);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL zm_ne_q: got %0b want 1", q); end
    strobe(4'b0010, 1'b0, 32'd1);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL zm_gt_q: got %0b want 1", q); end
    strobe(4'b0100, 1'b0, 32'd0);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL zm_ge_q: got %0b want 1", q); end
    strobe(4'b0101, 1'b0, 32'd1);
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL zm_le_q: got %0b want 0", q); end
    strobe(4'b0110, 1'b0, 32'h8000_0000);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL zm_gtu_q: got %0b want 1", q); end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL zm_count: got %0d want %0d", taken_count, exp_cnt); end
  endtask

  task automatic test_two_operand();
    int busy_cycles;
    for (int rep = 0; rep < 2; rep++) begin
      // The condition on the A strobe is unconditional. The field must be
      // re-sampled on the completing strobe.
      strobe(4'b1000, 1'b1, 32'd5);
      busy_cycles = 0;
      if (busy === 1'b1) busy_cycles++;
      checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL to_a_no_valid: got %0b want 0", q_valid); end
      for (int i = 0; i < 3; i++) begin
        cmp_mode = 1'b0;  // ignored in WAIT_B
        tick();
        if (busy === 1'b1) busy_cycles++;
      end
      checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL to_wait_no_valid: got %0b want 0", q_valid); end
      strobe(rep == 0 ? 4'b0010 : 4'b0011, 1'b0, 32'd7);
      if (rep == 1) exp_cnt++;
      checks++; if (busy_cycles != 4) begin errors++; $display("FAIL to_busy_cycles: got %0d want 4", busy_cycles); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_drop: got %0b want 0", busy); end
      checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %0b want 1", q_valid); end
      checks++; if (q !== (rep == 1)) begin errors++; $display("FAIL to_q rep%0d: got %0b want %0b", rep, q, rep == 1); end
    end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL to_count: got %0d want %0d", taken_count, exp_cnt); end
  endtask

  task automatic test_unsigned();
    strobe(4'b0000, 1'b1, 32'h8000_0000);
    strobe(4'b0110, 1'b1, 32'd1);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL un_gtu_q: got %0b want 1", q); end
    strobe(4'b0000, 1'b1, 32'h8000_0000);
    strobe(4'b0010, 1'b1, 32'd1);
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL un_gt_signed_q: got %0b want 0", q); end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL un_count: got %0d want %0d", taken_count, exp_cnt); end
  endtask

  task automatic test_unconditional();
    strobe(4'b1000, 1'b0, 32'd0);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL uc_zero_q: got %0b want 1", q); end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL uc_count1: got %0d want %0d", taken_count, exp_cnt); end
    // EQ would be false here; bit 3 forces the result to 1.
    strobe(4'b1000, 1'b0, 32'h1234_5678);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL uc_any_q: got %0b want 1", q); end
    strobe(4'b0000, 1'b1, 32'd9);
    strobe(4'b1111, 1'b0, 32'd1);  exp_cnt++;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL uc_twoop_q: got %0b want 1", q); end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL uc_count3: got %0d want %0d", taken_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    strobe(4'b0011, 1'b0, 32'hFFFF_FFFF);
    checks++; if (q_valid !== 1'b1 || q !== 1'b1) begin errors++; $display("FAIL b2b_0: got valid=%0b q=%0b want 1/1", q_valid, q); end
    strobe(4'b0000, 1'b0, 32'd5);
    checks++; if (q_valid !== 1'b1 || q !== 1'b0) begin errors++; $display("FAIL b2b_1: got valid=%0b q=%0b want 1/0", q_valid, q); end
    strobe(4'b1000, 1'b0, 32'd5);
    checks++; if (q_valid !== 1'b1 || q !== 1'b1) begin errors++; $display("FAIL b2b_2: got valid=%0b q=%0b want 1/1", q_valid, q); end
    exp_cnt += 2;
    tick();
    checks++; if (q_valid !== 1'b0 || q !== 1'b1) begin errors++; $display("FAIL b2b_end: got valid=%0b q=%0b want 0/1", q_valid, q); end
    checks++; if (taken_count !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", taken_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    reset = 1'b1; tick(); reset = 1'b0;
    exp_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      strobe(4'b1000, 1'b0, 32'(i));
      exp_cnt++;
      checks++;
      if (taken_count2 !== 4'((i > 15) ? 15 : i)) begin
        errors++; $display("FAIL sat_count2 step%0d: got %0d want %0d", i, taken_count2, (i > 15) ? 15 : i);
      end
    end
    checks++; if (taken_count !== 16'd20) begin errors++; $display("FAIL sat_count_wide: got %0d want 20", taken_count); end
  endtask

  task automatic test_reset_wait_b();
    strobe(4'b0000, 1'b1, 32'd9);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_pre: got %0b want 1", busy); end
    // Reset with a coincident completing strobe that would otherwise be taken.
    reset = 1'b1;
    strobe(4'b1000, 1'b0, 32'd2);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_busy: got %0b want 0", busy); end
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL rw_q: got %0b want 0", q); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %0b want 0", q_valid); end
    checks++; if (taken_count !== 16'd0) begin errors++; $display("FAIL rw_count: got %0d want 0", taken_count); end
    // The next strobe is an IDLE strobe and latches a fresh A = 4.
    strobe(4'b0000, 1'b1, 32'd4);
    checks++; if (busy !== 1'b1 || q_valid !== 1'b0) begin errors++; $display("FAIL rw_relatch: got busy=%0b valid=%0b want 1/0", busy, q_valid); end
    strobe(4'b0000, 1'b0, 32'd4);
    checks++; if (q_valid !== 1'b1 || q !== 1'b1) begin errors++; $display("FAIL rw_new_a: got valid=%0b q=%0b want 1/1", q_valid, q); end
  endtask

  initial begin
    reset = 1'b1; CONin = 1'b0; cmp_mode = 1'b0; IR = '0; busContents = '0;
    #1;
    test_reset();
    test_zero_mode();
    test_two_operand();
    test_unsigned();
    test_unconditional();
    test_back_to_back();
    test_saturation();
    test_reset_wait_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
